// File: rtl/kf8255_port_handshake_if.sv
// Bus/handshake bundle for one KF8255 Mode 1 port sequencer.
// master = CPU/pin side driving the sequencer, slave = the sequencer itself.
interface kf8255_port_handshake_if;
    logic       mode_enable;
    logic       port_io;
    logic [7:0] internal_data_bus;
    logic       write_port;
    logic       read_port;
    logic       inte_write;
    logic       inte_value;
    logic       strobe_n;
    logic       ack_n;
    logic [7:0] port_data_in;
    logic [7:0] input_latch;
    logic [7:0] port_data_out;
    logic       port_out_enable;
    logic       ibf;
    logic       obf_n;
    logic       intr;
    logic       inte;

    modport master (
        output mode_enable, port_io, internal_data_bus, write_port, read_port,
               inte_write, inte_value, strobe_n, ack_n, port_data_in,
        input  input_latch, port_data_out, port_out_enable, ibf, obf_n, intr, inte
    );

    modport slave (
        input  mode_enable, port_io, internal_data_bus, write_port, read_port,
               inte_write, inte_value, strobe_n, ack_n, port_data_in,
        output input_latch, port_data_out, port_out_enable, ibf, obf_n, intr, inte
    );
endinterface

// File: rtl/kf8255_port_handshake.sv
// Mode 1 strobed-handshake sequencer for one 8-bit KF8255 port: owns the data
// latches, IBF/STB# or OBF#/ACK# handshake, INTE and INTR.
module kf8255_port_handshake (
    input logic                    clock,
    input logic                    reset,
    kf8255_port_handshake_if.slave bus
);
    typedef enum logic [2:0] {
        DISABLED,
        IN_EMPTY,
        IN_FULL,
        OUT_EMPTY,
        OUT_FULL
    } state_t;

    state_t     state_q, state_d;
    logic       strobe_q, ack_q;
    logic       ibf_q, ibf_d;
    logic       obf_n_q, obf_n_d;
    logic       intr_q, intr_d;
    logic       inte_q, inte_d;
    logic [7:0] latch_q, latch_d;
    logic [7:0] dout_q, dout_d;

    logic stb_fall, stb_rise, ack_fall, ack_rise, in_dir;

    assign stb_fall = strobe_q & ~bus.strobe_n;
    assign stb_rise = ~strobe_q & bus.strobe_n;
    assign ack_fall = ack_q & ~bus.ack_n;
    assign ack_rise = ~ack_q & bus.ack_n;
    assign in_dir   = (state_q == IN_EMPTY) || (state_q == IN_FULL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= DISABLED;
            strobe_q <= 1'b1;
            ack_q    <= 1'b1;
            ibf_q    <= 1'b0;
            obf_n_q  <= 1'b1;
            intr_q   <= 1'b0;
            inte_q   <= 1'b0;
            latch_q  <= 8'h00;
            dout_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            strobe_q <= bus.strobe_n;
            ack_q    <= bus.ack_n;
            ibf_q    <= ibf_d;
            obf_n_q  <= obf_n_d;
            intr_q   <= intr_d;
            inte_q   <= inte_d;
            latch_q  <= latch_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ibf_d   = ibf_q;
        obf_n_d = obf_n_q;
        intr_d  = intr_q;
        inte_d  = inte_q;
        latch_d = latch_q;
        dout_d  = dout_q;

        if (bus.inte_write) inte_d = bus.inte_value;
        // The output latch accepts CPU writes unless the port is a Mode 1 input.
        if (bus.write_port && !(bus.mode_enable && bus.port_io)) dout_d = bus.internal_data_bus;

        if (!bus.mode_enable) begin
            state_d = DISABLED;
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
        end else if (state_q == DISABLED || in_dir != bus.port_io) begin
            state_d = bus.port_io ? IN_EMPTY : OUT_EMPTY;
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
        end else if (in_dir) begin
            if (stb_rise && ibf_q && inte_q) intr_d = 1'b1;
            if (bus.read_port && state_q == IN_FULL) begin
                state_d = IN_EMPTY;
                ibf_d   = 1'b0;
                intr_d  = 1'b0;
            end
            // A strobe overrides a same-cycle read so the new byte is not lost.
            if (stb_fall) begin
                state_d = IN_FULL;
                ibf_d   = 1'b1;
                latch_d = bus.port_data_in;
            end
        end else begin
            if (ack_rise && obf_n_q && inte_q) intr_d = 1'b1;
            if (bus.write_port) begin
                state_d = OUT_FULL;
                obf_n_d = 1'b0;
                intr_d  = 1'b0;
            end else if (ack_fall && state_q == OUT_FULL) begin
                state_d = OUT_EMPTY;
                obf_n_d = 1'b1;
            end
        end

        if (!inte_q) intr_d = 1'b0;
    end

    assign bus.input_latch     = latch_q;
    assign bus.port_data_out   = dout_q;
    assign bus.port_out_enable = bus.mode_enable & ~bus.port_io;
    assign bus.ibf             = ibf_q;
    assign bus.obf_n           = obf_n_q;
    assign bus.intr            = intr_q;
    assign bus.inte            = inte_q;
endmodule

// File: tb/tb_kf8255_port_handshake.sv
// Directed handshake scenarios plus randomized traffic checked against a
// buffer-level reference model of the Mode 1 port.
module tb_kf8255_port_handshake;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    kf8255_port_handshake_if ifc();

    kf8255_port_handshake dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: direction (0 none, 1 input, 2 output), buffer full flag.
    int         m_dir;
    bit         m_full, m_intr, m_inte;
    logic [7:0] m_latch, m_dout;
    bit         p_stb, p_ack;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dir   = 0;
        m_full  = 1'b0;
        m_intr  = 1'b0;
        m_inte  = 1'b0;
        m_latch = 8'h00;
        m_dout  = 8'h00;
        p_stb   = 1'b1;
        p_ack   = 1'b1;
    endtask

    task automatic model_edge();
        bit fs, rs, fa, ra, old_inte, was_full;
        int want;
        if (reset) begin
            model_reset();
            return;
        end
        fs = p_stb && !ifc.strobe_n;
        rs = !p_stb && ifc.strobe_n;
        fa = p_ack && !ifc.ack_n;
        ra = !p_ack && ifc.ack_n;
        p_stb = ifc.strobe_n;
        p_ack = ifc.ack_n;
        old_inte = m_inte;
        was_full = m_full;
        if (ifc.inte_write) m_inte = ifc.inte_value;
        if (ifc.write_port && !(ifc.mode_enable && ifc.port_io)) m_dout = ifc.internal_data_bus;
        want = ifc.port_io ? 1 : 2;
        if (!ifc.mode_enable) begin
            m_dir = 0; m_full = 1'b0; m_intr = 1'b0;
        end else if (m_dir != want) begin
            m_dir = want; m_full = 1'b0; m_intr = 1'b0;
        end else if (m_dir == 1) begin
            if (rs && was_full && old_inte) m_intr = 1'b1;
            if (ifc.read_port && was_full) begin m_full = 1'b0; m_intr = 1'b0; end
            if (fs) begin m_latch = ifc.port_data_in; m_full = 1'b1; end
        end else begin
            if (ra && !was_full && old_inte) m_intr = 1'b1;
            if (ifc.write_port) begin m_full = 1'b1; m_intr = 1'b0; end
            else if (fa && was_full) m_full = 1'b0;
        end
        if (!old_inte) m_intr = 1'b0;
    endtask

    task automatic check_all();
        chk("ibf",      8'(ifc.ibf),             8'(m_dir == 1 && m_full));
        chk("obf_n",    8'(ifc.obf_n),           8'(!(m_dir == 2 && m_full)));
        chk("intr",     8'(ifc.intr),            8'(m_intr));
        chk("inte",     8'(ifc.inte),            8'(m_inte));
        chk("latch",    ifc.input_latch,         m_latch);
        chk("dout",     ifc.port_data_out,       m_dout);
        chk("out_en",   8'(ifc.port_out_enable), 8'(ifc.mode_enable && !ifc.port_io));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        reset                 = 1'b1;
        ifc.mode_enable       = 1'b0;
        ifc.port_io           = 1'b1;
        ifc.internal_data_bus = 8'h00;
        ifc.write_port        = 1'b0;
        ifc.read_port         = 1'b0;
        ifc.inte_write        = 1'b0;
        ifc.inte_value        = 1'b0;
        ifc.strobe_n          = 1'b1;
        ifc.ack_n             = 1'b1;
        ifc.port_data_in      = 8'h00;
        model_reset();
        @(negedge clock);
        check_all();
        chk("rst_ibf", 8'(ifc.ibf), 8'h00);
        chk("rst_obf_n", 8'(ifc.obf_n), 8'h01);
        reset = 1'b0;

        // Input strobe with INTE clear
        ifc.mode_enable = 1'b1; ifc.port_io = 1'b1; ifc.port_data_in = 8'hA5;
        step();
        ifc.strobe_n = 1'b0;
        step();
        chk("in1_ibf", 8'(ifc.ibf), 8'h01);
        chk("in1_latch", ifc.input_latch, 8'hA5);
        step();
        ifc.strobe_n = 1'b1;
        step();
        chk("in1_intr", 8'(ifc.intr), 8'h00);

        // INTE set, second strobe, then CPU read
        ifc.inte_write = 1'b1; ifc.inte_value = 1'b1;
        step();
        ifc.inte_write = 1'b0;
        chk("inte_set", 8'(ifc.inte), 8'h01);
        ifc.port_data_in = 8'h3C; ifc.strobe_n = 1'b0;
        step();
        step();
        ifc.strobe_n = 1'b1;
        step();
        chk("in2_intr", 8'(ifc.intr), 8'h01);
        chk("in2_latch", ifc.input_latch, 8'h3C);
        ifc.read_port = 1'b1;
        step();
        ifc.read_port = 1'b0;
        chk("rd_ibf", 8'(ifc.ibf), 8'h00);
        chk("rd_intr", 8'(ifc.intr), 8'h00);

        // Output handshake
        ifc.port_io = 1'b0;
        step();
        ifc.internal_data_bus = 8'h5A; ifc.write_port = 1'b1;
        step();
        ifc.write_port = 1'b0;
        chk("wr_dout", ifc.port_data_out, 8'h5A);
        chk("wr_obf_n", 8'(ifc.obf_n), 8'h00);
        chk("wr_oe", 8'(ifc.port_out_enable), 8'h01);
        ifc.ack_n = 1'b0;
        step();
        chk("ack_obf_n", 8'(ifc.obf_n), 8'h01);
        ifc.ack_n = 1'b1;
        step();
        chk("ack_intr", 8'(ifc.intr), 8'h01);
        ifc.internal_data_bus = 8'hC3; ifc.write_port = 1'b1;
        step();
        ifc.write_port = 1'b0;
        chk("wr2_intr", 8'(ifc.intr), 8'h00);
        chk("wr2_obf_n", 8'(ifc.obf_n), 8'h00);

        // Drop mode mid-handshake
        ifc.mode_enable = 1'b0;
        #1;
        chk("dis_oe", 8'(ifc.port_out_enable), 8'h00);
        step();
        chk("dis_obf_n", 8'(ifc.obf_n), 8'h01);
        chk("dis_dout", ifc.port_data_out, 8'hC3);
        chk("dis_inte", 8'(ifc.inte), 8'h01);

        // Same-cycle read and strobe fall
        ifc.mode_enable = 1'b1; ifc.port_io = 1'b1;
        step();
        ifc.port_data_in = 8'h11; ifc.strobe_n = 1'b0;
        step();
        ifc.strobe_n = 1'b1;
        step();
        ifc.port_data_in = 8'h77; ifc.strobe_n = 1'b0; ifc.read_port = 1'b1;
        step();
        ifc.read_port = 1'b0;
        chk("race_ibf", 8'(ifc.ibf), 8'h01);
        chk("race_latch", ifc.input_latch, 8'h77);
        ifc.strobe_n = 1'b1;
        step();
        chk("pre_rst_intr", 8'(ifc.intr), 8'h01);

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_ibf", 8'(ifc.ibf), 8'h00);
        chk("arst_intr", 8'(ifc.intr), 8'h00);
        chk("arst_latch", ifc.input_latch, 8'h00);
        step();
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ifc.mode_enable = ~ifc.mode_enable;
            if ($urandom_range(0, 59) == 0) ifc.port_io = ~ifc.port_io;
            if ($urandom_range(0, 3) == 0) ifc.strobe_n = ~ifc.strobe_n;
            if ($urandom_range(0, 3) == 0) ifc.ack_n = ~ifc.ack_n;
            ifc.read_port         = ($urandom_range(0, 4) == 0);
            ifc.write_port        = ($urandom_range(0, 4) == 0);
            ifc.inte_write        = ($urandom_range(0, 7) == 0);
            ifc.inte_value        = ($urandom_range(0, 3) != 0);
            ifc.internal_data_bus = 8'($urandom);
            ifc.port_data_in      = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
